// File: rtl/sap_pkg.sv
// sap_pkg: shared definitions for the SAP fetch/execute sequencer.
//   Widths of the address, data and opcode fields, the opcode constants,
//   the one-hot T-state encoding and a small opcode-class helper.
package sap_pkg;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned T_W    = 6;

  localparam logic [OP_W-1:0] OP_LDA = 4'b0000;
  localparam logic [OP_W-1:0] OP_ADD = 4'b0001;
  localparam logic [OP_W-1:0] OP_SUB = 4'b0010;
  localparam logic [OP_W-1:0] OP_OUT = 4'b1110;
  localparam logic [OP_W-1:0] OP_HLT = 4'b1111;

  // One-hot T-states, bit 0 = T1
  typedef enum logic [T_W-1:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } t_state_e;

  // Opcodes that fetch an operand from RAM during T5
  function automatic logic is_mem_op(input logic [OP_W-1:0] op);
    return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/sap_ring_counter.sv
// sap_ring_counter: 6-bit one-hot T-state ring counter, T1..T6 then back to T1.
//   clk     in  rising-edge clock
//   rst     in  synchronous active-high reset, returns to T1
//   hold    in  freeze the current state (halted)
//   restart in  return to T1 at the next edge (early end of instruction)
//   t_state out current one-hot state, bit 0 = T1
module sap_ring_counter
  import sap_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           hold,
  input  logic           restart,
  output logic [T_W-1:0] t_state
);

  t_state_e r_state;
  t_state_e w_next;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= T1;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state: hold has priority over restart, otherwise rotate
  always_comb begin
    w_next = r_state;
    if (!hold) begin
      if (restart) begin
        w_next = T1;
      end else begin
        case (r_state)
          T1:      w_next = T2;
          T2:      w_next = T3;
          T3:      w_next = T4;
          T4:      w_next = T5;
          T5:      w_next = T6;
          T6:      w_next = T1;
          default: w_next = T1;
        endcase
      end
    end
  end

  assign t_state = r_state;

endmodule

// File: rtl/sap_sequencer.sv
// sap_sequencer: fetch/execute controller for the 8-bit SAP processor.
//   Holds PC, MAR and IR, reads the 16x8 RAM and issues per-T-state strobes.
//   Optional feature macro: SAP_SEQ_VAR_CYCLE_EN (variable-length machine
//   cycle; undefined = every instruction takes T1..T6).
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   w_bus     in  8     W bus, captured into IR in T3
//   mem_addr  out 4     RAM address (= MAR)
//   mem_ce_n  out 1     RAM chip enable, active low
//   acc_load, acc_en, b_load, alu_en, alu_sub, out_load   control strobes
//   halted    out 1     sticky halt flag
//   t_state   out 6     one-hot T-state
//   pc        out 4     program counter (debug)
module sap_sequencer
  import sap_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] w_bus,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_ce_n,
  output logic              acc_load,
  output logic              acc_en,
  output logic              b_load,
  output logic              alu_en,
  output logic              alu_sub,
  output logic              out_load,
  output logic              halted,
  output logic [T_W-1:0]    t_state,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_mar;
  logic [DATA_W-1:0] r_ir;
  logic              r_halted;

  logic [T_W-1:0]    w_t;
  logic [OP_W-1:0]   w_op;
  logic              w_lda;
  logic              w_add;
  logic              w_sub;
  logic              w_out;
  logic              w_hlt;
  logic              w_nop;
  logic              w_restart;

  // Opcode decode
  assign w_op  = r_ir[DATA_W-1 -: OP_W];
  assign w_lda = (w_op == OP_LDA);
  assign w_add = (w_op == OP_ADD);
  assign w_sub = (w_op == OP_SUB);
  assign w_out = (w_op == OP_OUT);
  assign w_hlt = (w_op == OP_HLT);
  assign w_nop = !(w_lda || w_add || w_sub || w_out || w_hlt);

`ifdef SAP_SEQ_VAR_CYCLE_EN
  // End the machine cycle after the last state that does work; T6 wraps anyway
  assign w_restart = ((w_t == T4) && (w_out || w_nop)) ||
                     ((w_t == T5) && w_lda);
`else
  assign w_restart = 1'b0;
`endif

  sap_ring_counter u_ring (
    .clk     (clk),
    .rst     (rst),
    .hold    (r_halted),
    .restart (w_restart),
    .t_state (w_t)
  );

  // PC / MAR / IR / halt registers; everything freezes once halted
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc     <= '0;
      r_mar    <= '0;
      r_ir     <= '0;
      r_halted <= 1'b0;
    end else if (!r_halted) begin
      if (w_t == T1) r_mar <= r_pc;
      if (w_t == T2) r_pc  <= r_pc + ADDR_W'(1);
      if (w_t == T3) r_ir  <= w_bus;
      if (w_t == T4) begin
        if (is_mem_op(w_op)) r_mar    <= r_ir[ADDR_W-1:0];
        if (w_hlt)           r_halted <= 1'b1;
      end
    end
  end

  // Strobe decode; reset and halt force every strobe inactive
  always_comb begin
    mem_ce_n = 1'b1;
    acc_load = 1'b0;
    acc_en   = 1'b0;
    b_load   = 1'b0;
    alu_en   = 1'b0;
    alu_sub  = 1'b0;
    out_load = 1'b0;
    if (!rst && !r_halted) begin
      case (w_t)
        T3: mem_ce_n = 1'b0;
        T4: begin
          if (w_out) begin
            acc_en   = 1'b1;
            out_load = 1'b1;
          end
        end
        T5: begin
          if (w_lda) begin
            mem_ce_n = 1'b0;
            acc_load = 1'b1;
          end else if (w_add || w_sub) begin
            mem_ce_n = 1'b0;
            b_load   = 1'b1;
          end
        end
        T6: begin
          if (w_add || w_sub) begin
            alu_en   = 1'b1;
            acc_load = 1'b1;
            alu_sub  = w_sub;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_addr = r_mar;
  assign halted   = r_halted;
  assign t_state  = w_t;
  assign pc       = r_pc;

endmodule

// File: doc/sap_sequencer.md
# sap_sequencer

Fetch/execute controller for the 8-bit SAP processor. It is the reading master of the 16×8 program/data RAM. It holds the program counter (PC), the memory address register (MAR) and the instruction register (IR). It drives the RAM address and active-low chip enable, and captures the instruction byte from the W bus. It also steps a T-state ring counter that issues the per-cycle control strobes for the accumulator, B register, ALU and output register.

## Interface
- No parameters; widths are fixed by the architecture: 4-bit address, 8-bit bus, 4-bit opcode.
- `clk  in  1`  rising-edge clock.
- `rst  in  1`  synchronous, active-high reset.
- `w_bus  in  8`  W bus value as driven by the RAM (or another source); sampled only as described below.
- `mem_addr  out  4`  RAM address; always equals MAR.
- `mem_ce_n  out  1`  RAM chip enable, active low; asserted only in memory-read states.
- `acc_load  out  1`  accumulator loads this cycle (W bus in T5 LDA, ALU result in T6).
- `acc_en  out  1`  accumulator drives the W bus (OUT).
- `b_load  out  1`  B register loads the W bus.
- `alu_en  out  1`  ALU result is selected into the accumulator.
- `alu_sub  out  1`  1 = subtract, 0 = add; meaningful only when `alu_en=1`.
- `out_load  out  1`  output register loads.
- `halted  out  1`  sticky; set by HLT.
- `t_state  out  6`  one-hot T-state, bit 0 = T1.
- `pc  out  4`  current PC, for debug.

## Operation
- Opcodes, from IR[7:4]:
  - LDA = 0000
  - ADD = 0001
  - SUB = 0010
  - OUT = 1110
  - HLT = 1111
  - any other opcode is a NOP.
- Operand address is IR[3:0].
- Strobes are combinational decodes of `t_state` and IR. Every strobe not listed in a state is 0.
- **T1:** MAR ← PC at the closing edge.
- **T2:** PC ← PC+1 at the closing edge; 4-bit wrap, 15 → 0.
- **T3:** `mem_ce_n=0`; IR ← `w_bus` at the closing edge.
- **T4:**
  - LDA/ADD/SUB: MAR ← IR[3:0].
  - OUT: `acc_en=1`, `out_load=1`.
  - HLT: `halted` ← 1.
  - NOP: no action.
- **T5:**
  - LDA: `mem_ce_n=0`, `acc_load=1`.
  - ADD/SUB: `mem_ce_n=0`, `b_load=1`.
  - Others: idle.
- **T6:**
  - ADD: `alu_en=1`, `acc_load=1`, `alu_sub=0`.
  - SUB: same, with `alu_sub=1`.
  - Others: idle.
- T6 → T1.
- **Halted state:**
  - `t_state` freezes at T5.
  - PC, MAR and IR hold.
  - All strobes are 0 and `mem_ce_n=1`.
  - Only `rst` clears `halted`.
- **Reset:**
  - `t_state` = 000001, PC = 0, MAR = 0, IR = 0, `halted` = 0.
  - While `rst=1`, all strobes are forced to 0 and `mem_ce_n=1`.
  - Reset mid-instruction aborts the instruction immediately. No partial strobe is issued in the reset cycle.
- The block never drives `w_bus`. It is an input only, and bus contention is the bus owner's concern.

## Timing
- One T-state per clock.
- Fixed machine cycle is 6 clocks per instruction (see Configuration).
- `mem_addr` is registered: it is valid from the edge that opens T2 and from the edge that opens T5.
- The RAM read is combinational, so data is valid within the same cycle that `mem_ce_n` is low.
- IR and the accumulator/B register sample the bus at the edge closing that cycle.
- `halted` rises at the edge closing T4 of HLT.
- The first instruction is fetched from address 0 on the first cycle after `rst` deasserts.

## Configuration
- Macro: `SAP_SEQ_VAR_CYCLE_EN`.
- **Defined:** the ring counter returns to T1 early, after the instruction's last active state:
  - LDA after T5.
  - OUT and NOP after T4.
  - ADD/SUB after T6.
  - HLT unchanged (halts at T4).
- **Undefined:** every instruction occupies T1–T6, and idle states emit no strobes.

## Structure
- Shared package `sap_pkg`:
  - opcode constants `OP_LDA`, `OP_ADD`, `OP_SUB`, `OP_OUT`, `OP_HLT`;
  - one-hot T-state constants `T1`…`T6`;
  - widths `ADDR_W=4`, `DATA_W=8`.
- Sub-module `sap_ring_counter`: 6-bit one-hot counter with `clk`, `rst`, `hold` (halt) and `restart` (early return to T1).
- The top level holds PC, MAR, IR and the decode.

## Test plan
- **Fixed-cycle program.** RAM holds 05, 1A, 2C, E0, F0 with data [5]=AA, [A]=55, [C]=77. Required response:
  - fetch addresses 0,1,2,3,4;
  - `acc_load` with `mem_addr`=5 in cycle 4;
  - `b_load` with `mem_addr`=A in cycle 10 and `alu_en=1`, `alu_sub=0` in cycle 11;
  - `b_load` with `mem_addr`=C in cycle 16 and `alu_sub=1` in cycle 17;
  - `out_load` in cycle 21;
  - `halted` rises at the edge ending cycle 27.
- **Same program with `SAP_SEQ_VAR_CYCLE_EN` defined:** LDA takes 5 cycles, ADD and SUB 6 each, OUT 4. `halted` rises at the edge ending cycle 24.
- **PC wrap:** 16 NOPs (opcode 0111) → PC goes 15→0; the 17th fetch is at `mem_addr`=0.
- **Halt freeze:** after HLT, hold for 20 cycles → `t_state`=T5; PC, `mem_addr` and all strobes are constant; `mem_ce_n`=1.
- **Reset mid-ADD:** assert `rst` in T5 → no `b_load` during the reset cycle. The next cycle after release is T1, with PC=0 and MAR=0.
- **Unknown opcode 0x3F:** no strobes in T4–T6; PC advances by exactly 1.
